// File: rtl/prefetch_issue_queue.sv
// Queue between the best-offset prefetcher and the lower-level cache: drops page-crossing,
// duplicate and overflow candidates, issues the rest in order over valid/ready, and counts each outcome.
module prefetch_issue_queue #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 8,
    parameter int FILTER    = 8,
    parameter int LOGLINE   = 6,
    parameter int LOGPAGE   = 12,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pf_valid_i,
    input  logic [WIDTH-1:0]     pf_address_i,
    input  logic [WIDTH-1:0]     pf_trigger_i,
    input  logic                 lo_ready_i,
    output logic                 lo_prefetch_valid_o,
    output logic [WIDTH-1:0]     lo_prefetch_address_o,
    output logic [CNT_WIDTH-1:0] issued_count_o,
    output logic [CNT_WIDTH-1:0] drop_page_o,
    output logic [CNT_WIDTH-1:0] drop_dup_o,
    output logic [CNT_WIDTH-1:0] drop_full_o
);

    localparam int LW   = WIDTH - LOGLINE;
    localparam int PTRW = $clog2(DEPTH);
    localparam int FPW  = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [PTRW:0] DEPTH_C = (PTRW + 1)'(DEPTH);

    logic [LW-1:0]        fifo_mem [DEPTH];
    logic [PTRW-1:0]      head_reg;
    logic [PTRW-1:0]      tail_reg;
    logic [PTRW:0]        count_reg;
    logic [PTRW:0]        count_next;
    logic [LW-1:0]        filter_mem [FILTER];
    logic [FILTER-1:0]    filter_valid_reg;
    logic [FPW-1:0]       filter_ptr_reg;
    logic [CNT_WIDTH-1:0] issued_reg;
    logic [CNT_WIDTH-1:0] drop_page_reg;
    logic [CNT_WIDTH-1:0] drop_dup_reg;
    logic [CNT_WIDTH-1:0] drop_full_reg;

    logic [LW-1:0]     cand_line;
    logic [LW-1:0]     head_line;
    logic [DEPTH-1:0]  fifo_hit;
    logic [FILTER-1:0] filter_hit;
    logic              page_cross;
    logic              dup;
    logic              deq;
    logic              full;
    logic              enq;
    logic              drop_page;
    logic              drop_dup;
    logic              drop_full;
    logic              unused_bits;

    assign cand_line   = pf_address_i[WIDTH-1:LOGLINE];
    assign head_line   = fifo_mem[head_reg];
    assign unused_bits = ^{pf_trigger_i[LOGPAGE-1:0], pf_address_i[LOGLINE-1:0]};

    // An entry is occupied when its distance from head is below count; the head itself
    // still counts in the cycle it is being popped.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_fifo_cmp
            logic [PTRW-1:0] offset;
            assign offset       = PTRW'(gi) - head_reg;
            assign fifo_hit[gi] = ({1'b0, offset} < count_reg) && (fifo_mem[gi] == cand_line);
        end
        for (gi = 0; gi < FILTER; gi++) begin : g_filter_cmp
            assign filter_hit[gi] = filter_valid_reg[gi] && (filter_mem[gi] == cand_line);
        end
    endgenerate

    assign page_cross = pf_address_i[WIDTH-1:LOGPAGE] != pf_trigger_i[WIDTH-1:LOGPAGE];
    assign dup        = (|fifo_hit) || (|filter_hit);
    assign deq        = (count_reg != '0) && lo_ready_i;
    assign full       = (count_reg == DEPTH_C) && !deq;

    assign drop_page = pf_valid_i && page_cross;
    assign drop_dup  = pf_valid_i && !page_cross && dup;
    assign drop_full = pf_valid_i && !page_cross && !dup && full;
    assign enq       = pf_valid_i && !page_cross && !dup && !full;

    always_comb begin
        count_next = count_reg;
        if (enq && !deq) begin
            count_next = count_reg + 1'b1;
        end else if (!enq && deq) begin
            count_next = count_reg - 1'b1;
        end
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Storage arrays carry no reset; occupancy and filter valid bits qualify their contents.
    always_ff @(posedge clk) begin
        if (rst && enq) begin
            fifo_mem[tail_reg] <= cand_line;
        end
        if (rst && deq) begin
            filter_mem[filter_ptr_reg] <= head_line;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_reg         <= '0;
            tail_reg         <= '0;
            count_reg        <= '0;
            filter_valid_reg <= '0;
            filter_ptr_reg   <= '0;
            issued_reg       <= '0;
            drop_page_reg    <= '0;
            drop_dup_reg     <= '0;
            drop_full_reg    <= '0;
        end else begin
            count_reg <= count_next;
            if (enq) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (deq) begin
                head_reg                         <= head_reg + 1'b1;
                filter_valid_reg[filter_ptr_reg] <= 1'b1;
                filter_ptr_reg <= (filter_ptr_reg == FPW'(FILTER - 1)) ? '0 : filter_ptr_reg + 1'b1;
                issued_reg     <= sat_inc(issued_reg);
            end
            if (drop_page) begin
                drop_page_reg <= sat_inc(drop_page_reg);
            end
            if (drop_dup) begin
                drop_dup_reg <= sat_inc(drop_dup_reg);
            end
            if (drop_full) begin
                drop_full_reg <= sat_inc(drop_full_reg);
            end
        end
    end

    assign lo_prefetch_valid_o   = count_reg != '0;
    assign lo_prefetch_address_o = lo_prefetch_valid_o ? {head_line, {LOGLINE{1'b0}}} : '0;
    assign issued_count_o        = issued_reg;
    assign drop_page_o           = drop_page_reg;
    assign drop_dup_o            = drop_dup_reg;
    assign drop_full_o           = drop_full_reg;

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Bench for prefetch_issue_queue: directed vector table, multi-cycle corner sequences and
// random traffic compared against a queue-based reference model.
module tb_prefetch_issue_queue;

    localparam int WIDTH   = 64;
    localparam int DEPTH   = 8;
    localparam int FILTER  = 8;
    localparam int LOGLINE = 6;
    localparam int LOGPAGE = 12;
    localparam int CW      = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          pf_valid_i;
    logic [63:0]   pf_address_i;
    logic [63:0]   pf_trigger_i;
    logic          lo_ready_i;
    logic          lo_prefetch_valid_o;
    logic [63:0]   lo_prefetch_address_o;
    logic [CW-1:0] issued_count_o;
    logic [CW-1:0] drop_page_o;
    logic [CW-1:0] drop_dup_o;
    logic [CW-1:0] drop_full_o;

    always #5 clk = ~clk;

    prefetch_issue_queue #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .FILTER(FILTER),
        .LOGLINE(LOGLINE), .LOGPAGE(LOGPAGE), .CNT_WIDTH(CW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .pf_valid_i            (pf_valid_i),
        .pf_address_i          (pf_address_i),
        .pf_trigger_i          (pf_trigger_i),
        .lo_ready_i            (lo_ready_i),
        .lo_prefetch_valid_o   (lo_prefetch_valid_o),
        .lo_prefetch_address_o (lo_prefetch_address_o),
        .issued_count_o        (issued_count_o),
        .drop_page_o           (drop_page_o),
        .drop_dup_o            (drop_dup_o),
        .drop_full_o           (drop_full_o)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: pending lines in order, and the last FILTER issued lines.
    logic [63:0] m_q[$];
    logic [63:0] m_f[$];
    int m_iss, m_page, m_dup, m_full;

    typedef struct {
        bit          rn;
        bit          pv;
        logic [63:0] a;
        logic [63:0] t;
        bit          rdy;
        bit          ev;
        logic [63:0] ea;
        int          iss;
        int          pg;
        int          dup;
        int          full;
    } vec_t;
    vec_t tbl[12];

    logic [63:0] hs_log[$];
    logic [63:0] a0, last, ra, rt, rpg, rtp;
    bit          v0, rdy_b, pv_b;
    int          sent, hs;

    function automatic int sat(input int v);
        return (v >= (1 << CW) - 1) ? v : v + 1;
    endfunction

    function automatic bit seen(input logic [63:0] ln);
        foreach (m_q[i]) if (m_q[i] == ln) return 1'b1;
        foreach (m_f[i]) if (m_f[i] == ln) return 1'b1;
        return 1'b0;
    endfunction

    task automatic cmp(input string tag, input string f, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s %s: got 0x%0h, want 0x%0h", tag, f, act, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        cmp(tag, "value", act, exp);
    endtask

    // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
    task automatic cycle(input bit rn, input bit pv, input logic [63:0] a, input logic [63:0] t, input bit rdy);
        bit          deq;
        bit          enq;
        logic [63:0] ln;
        rst = rn; pf_valid_i = pv; pf_address_i = a; pf_trigger_i = t; lo_ready_i = rdy;
        if (!rn) begin
            m_q.delete(); m_f.delete();
            m_iss = 0; m_page = 0; m_dup = 0; m_full = 0;
        end else begin
            deq = (m_q.size() != 0) && rdy;
            enq = 1'b0;
            ln  = a >> LOGLINE;
            if (pv) begin
                if ((a >> LOGPAGE) != (t >> LOGPAGE)) m_page = sat(m_page);
                else if (seen(ln)) m_dup = sat(m_dup);
                else if (m_q.size() == DEPTH && !deq) m_full = sat(m_full);
                else enq = 1'b1;
            end
            if (deq) begin
                m_f.push_back(m_q.pop_front());
                if (m_f.size() > FILTER) void'(m_f.pop_front());
                m_iss = sat(m_iss);
            end
            if (enq) m_q.push_back(ln);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic        ev;
        logic [63:0] ea;
        n_vec++;
        ev = m_q.size() != 0;
        ea = ev ? (m_q[0] << LOGLINE) : 64'h0;
        cmp(tag, "valid", lo_prefetch_valid_o, ev);
        cmp(tag, "addr", lo_prefetch_address_o, ea);
        cmp(tag, "issued", issued_count_o, m_iss);
        cmp(tag, "drop_page", drop_page_o, m_page);
        cmp(tag, "drop_dup", drop_dup_o, m_dup);
        cmp(tag, "drop_full", drop_full_o, m_full);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rn pv addr      trig      rdy ev ea        iss pg dup full
        tbl[0]  = '{1, 1, 64'h1044, 64'h1000, 1, 1, 64'h1040, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 64'h0,    64'h0,    1, 0, 64'h0,    1, 0, 0, 0};
        tbl[2]  = '{1, 1, 64'h2000, 64'h1FC0, 1, 0, 64'h0,    1, 1, 0, 0};
        tbl[3]  = '{0, 1, 64'h3000, 64'h3000, 1, 0, 64'h0,    0, 0, 0, 0};
        tbl[4]  = '{1, 1, 64'h1040, 64'h1000, 0, 1, 64'h1040, 0, 0, 0, 0};
        tbl[5]  = '{1, 1, 64'h1078, 64'h1000, 0, 1, 64'h1040, 0, 0, 1, 0};
        tbl[6]  = '{1, 0, 64'h0,    64'h0,    1, 0, 64'h0,    1, 0, 1, 0};
        tbl[7]  = '{1, 1, 64'h1040, 64'h1000, 0, 0, 64'h0,    1, 0, 2, 0};
        tbl[8]  = '{1, 1, 64'h1080, 64'h1000, 0, 1, 64'h1080, 1, 0, 2, 0};
        tbl[9]  = '{1, 1, 64'h1080, 64'h1000, 1, 0, 64'h0,    2, 0, 3, 0};
        tbl[10] = '{1, 1, 64'h1FC0, 64'h1000, 0, 1, 64'h1FC0, 2, 0, 3, 0};
        tbl[11] = '{1, 0, 64'h0,    64'h0,    1, 0, 64'h0,    3, 0, 3, 0};

        rst = 1'b0; pf_valid_i = 1'b0; pf_address_i = '0; pf_trigger_i = '0; lo_ready_i = 1'b0;
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check_model("reset");

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].rn, tbl[i].pv, tbl[i].a, tbl[i].t, tbl[i].rdy);
            n_vec++;
            cmp($sformatf("tbl%0d", i), "valid", lo_prefetch_valid_o, tbl[i].ev);
            cmp($sformatf("tbl%0d", i), "addr", lo_prefetch_address_o, tbl[i].ea);
            cmp($sformatf("tbl%0d", i), "issued", issued_count_o, tbl[i].iss);
            cmp($sformatf("tbl%0d", i), "drop_page", drop_page_o, tbl[i].pg);
            cmp($sformatf("tbl%0d", i), "drop_dup", drop_dup_o, tbl[i].dup);
            cmp($sformatf("tbl%0d", i), "drop_full", drop_full_o, tbl[i].full);
        end

        // Full queue, then an enqueue together with a dequeue at count == DEPTH.
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            cycle(1, 1, 64'h5000 + i * 64'h40, 64'h5000, 0);
            check_model($sformatf("full_fill%0d", i));
        end
        expect_val("full_drop_count", drop_full_o, 1);
        expect_val("full_head", lo_prefetch_address_o, 64'h5000);
        cycle(1, 1, 64'h5240, 64'h5000, 1);
        check_model("full_simul");
        expect_val("full_simul_head", lo_prefetch_address_o, 64'h5040);
        expect_val("full_simul_drop", drop_full_o, 1);
        expect_val("full_simul_issued", issued_count_o, 1);
        hs = 0; last = '0;
        for (int c = 0; c < 20 && lo_prefetch_valid_o; c++) begin
            last = lo_prefetch_address_o;
            hs++;
            cycle(1, 0, 0, 0, 1);
            check_model($sformatf("full_drain%0d", c));
        end
        expect_val("full_drain_count", hs, 8);
        expect_val("full_drain_last", last, 64'h5240);

        // Back-pressure with 20 candidates; then filter wrap.
        cycle(0, 0, 0, 0, 0);
        hs_log.delete();
        sent = 0;
        for (int c = 0; c < 200 && (sent < 20 || lo_prefetch_valid_o); c++) begin
            rdy_b = ((c >> 1) & 1) != 0;
            pv_b  = (c % 2 == 0) && (sent < 20);
            v0 = lo_prefetch_valid_o;
            a0 = lo_prefetch_address_o;
            cycle(1, pv_b, 64'h7000 + sent * 64'h40, 64'h7000, rdy_b);
            if (pv_b) sent++;
            check_model($sformatf("bp%0d", c));
            if (v0 && rdy_b) hs_log.push_back(a0);
            if (v0 && !rdy_b) begin
                expect_val("bp_hold_valid", lo_prefetch_valid_o, 1);
                expect_val("bp_hold_addr", lo_prefetch_address_o, a0);
            end
        end
        expect_val("bp_issue_count", hs_log.size(), 20);
        for (int k = 0; k < 20; k++) begin
            expect_val($sformatf("bp_order%0d", k), (k < hs_log.size()) ? hs_log[k] : 64'hFFFF_FFFF_FFFF_FFFF,
                       64'h7000 + k * 64'h40);
        end
        cycle(1, 1, 64'h7000, 64'h7000, 0);
        check_model("wrap_resend_first");
        expect_val("wrap_first_valid", lo_prefetch_valid_o, 1);
        expect_val("wrap_first_addr", lo_prefetch_address_o, 64'h7000);
        expect_val("wrap_first_nodup", drop_dup_o, 0);
        cycle(1, 1, 64'h74C0, 64'h7000, 0);
        check_model("wrap_resend_last");
        expect_val("wrap_last_dup", drop_dup_o, 1);

        // Reset with five entries queued and non-zero counters.
        cycle(0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) cycle(1, 1, 64'h9000 + k * 64'h40, 64'h9000, 0);
        cycle(1, 1, 64'h9000, 64'h9000, 1);
        cycle(1, 1, 64'hA000, 64'h9FC0, 0);
        check_model("rst_pre");
        expect_val("rst_pre_valid", lo_prefetch_valid_o, 1);
        cycle(0, 1, 64'h9400, 64'h9000, 1);
        check_model("rst_mid");
        expect_val("rst_valid", lo_prefetch_valid_o, 0);
        expect_val("rst_addr", lo_prefetch_address_o, 0);
        expect_val("rst_issued", issued_count_o, 0);
        expect_val("rst_page", drop_page_o, 0);
        expect_val("rst_dup", drop_dup_o, 0);
        expect_val("rst_full", drop_full_o, 0);
        cycle(1, 1, 64'h9100, 64'h9000, 0);
        check_model("rst_after");
        expect_val("rst_after_valid", lo_prefetch_valid_o, 1);
        expect_val("rst_after_addr", lo_prefetch_address_o, 64'h9100);
        cycle(1, 1, 64'h9000, 64'h9000, 1);
        check_model("rst_after2");
        expect_val("rst_after_nodup", drop_dup_o, 0);
        expect_val("rst_after_issued", issued_count_o, 1);

        // Random traffic over two pages so duplicates, page crossings and overflow all occur.
        cycle(0, 0, 0, 0, 0);
        for (int c = 0; c < 1500; c++) begin
            rpg = 64'hA + 64'($urandom_range(0, 1));
            ra  = (rpg << 12) | (64'($urandom_range(0, 15)) << 6) | 64'($urandom_range(0, 63));
            rtp = ($urandom_range(0, 6) == 0) ? (rpg ^ 64'h1) : rpg;
            rt  = (rtp << 12) | 64'($urandom_range(0, 4095));
            cycle($urandom_range(0, 79) != 0, $urandom_range(0, 1) != 0, ra, rt, $urandom_range(0, 1) != 0);
            check_model($sformatf("rand%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
